// File: rtl/panda_risc_v_divider_param_if.sv
// Request/result bus of the iterative divider: request channel in, result channel out.
interface panda_risc_v_divider_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic [DATA_WIDTH-1:0] s_div_req_op_a;
  logic [DATA_WIDTH-1:0] s_div_req_op_b;
  logic                  s_div_req_signed;
  logic                  s_div_req_rem_sel;
  logic [ID_WIDTH-1:0]   s_div_req_id;
  logic                  s_div_req_valid;
  logic                  s_div_req_ready;
  logic [DATA_WIDTH-1:0] m_div_res_data;
  logic [ID_WIDTH-1:0]   m_div_res_id;
  logic                  m_div_res_valid;
  logic                  m_div_res_ready;

  modport slave (
    input  s_div_req_op_a, s_div_req_op_b, s_div_req_signed, s_div_req_rem_sel,
    input  s_div_req_id, s_div_req_valid, m_div_res_ready,
    output s_div_req_ready, m_div_res_data, m_div_res_id, m_div_res_valid
  );

  modport master (
    output s_div_req_op_a, s_div_req_op_b, s_div_req_signed, s_div_req_rem_sel,
    output s_div_req_id, s_div_req_valid, m_div_res_ready,
    input  s_div_req_ready, m_div_res_data, m_div_res_id, m_div_res_valid
  );
endinterface

// File: rtl/panda_risc_v_divider_param.sv
// Signed/unsigned non-restoring divider, one quotient bit per cycle, 2-entry request buffer,
// single-stage result register, in-order results.
module panda_risc_v_divider_param #(
  parameter int  DATA_WIDTH       = 32,
  parameter int  ID_WIDTH         = 4,
  parameter real simulation_delay = 1
) (
  input logic clk,
  input logic resetn,
  input logic flush,
  panda_risc_v_divider_param_if.slave div
);
  localparam int RW   = DATA_WIDTH + 2;
  localparam int CntW = $clog2(DATA_WIDTH + 1);
  localparam logic [DATA_WIDTH-1:0] MinNeg = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  if (DATA_WIDTH < 8 || DATA_WIDTH > 64 || simulation_delay < 0.0) begin : g_bad_param
    $error("panda_risc_v_divider_param: DATA_WIDTH must be 8..64");
  end

  typedef struct packed {
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  sgn;
    logic                  rem_sel;
    logic [ID_WIDTH-1:0]   id;
  } req_t;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  req_t   r_buf [2];
  logic   r_wptr, r_rptr, r_vis;
  logic [1:0] r_cnt;
  state_e r_state, w_state_d;
  logic [RW-1:0]         r_rem;
  logic [DATA_WIDTH-1:0] r_quo;
  logic [CntW-1:0]       r_cnt_calc;
  logic                  r_res_vld;
  logic [DATA_WIDTH-1:0] r_res_data;
  logic [ID_WIDTH-1:0]   r_res_id;

  req_t                  w_head, w_in;
  logic                  w_push, w_pop, w_preset, w_step, w_res_load, w_out_free;
  logic                  w_div_zero, w_ovf, w_sub;
  logic [DATA_WIDTH:0]   w_a_ext, w_b_ext;
  logic [RW-1:0]         w_b_rw, w_rem_sh, w_rem_nx, w_rem_fix;
  logic [DATA_WIDTH-1:0] w_quo_fix, w_res_data;

  assign w_in = '{op_a: div.s_div_req_op_a, op_b: div.s_div_req_op_b,
                  sgn: div.s_div_req_signed, rem_sel: div.s_div_req_rem_sel,
                  id: div.s_div_req_id};
  assign w_head     = r_buf[r_rptr];
  assign w_push     = div.s_div_req_valid & div.s_div_req_ready & ~flush;
  assign w_out_free = ~r_res_vld | div.m_div_res_ready;

  assign div.s_div_req_ready = (r_cnt != 2'd2);
  assign div.m_div_res_valid = r_res_vld;
  assign div.m_div_res_data  = r_res_data;
  assign div.m_div_res_id    = r_res_id;

  assign w_a_ext    = {w_head.sgn & w_head.op_a[DATA_WIDTH-1], w_head.op_a};
  assign w_b_ext    = {w_head.sgn & w_head.op_b[DATA_WIDTH-1], w_head.op_b};
  assign w_b_rw     = {w_b_ext[DATA_WIDTH], w_b_ext};
  assign w_div_zero = (w_head.op_b == '0);
  assign w_ovf      = w_head.sgn & (w_head.op_a == MinNeg) & (&w_head.op_b);

  // {r_rem, r_quo} shifts left; dividend bits leave r_quo while quotient digits enter it
  assign w_rem_sh = {r_rem[RW-2:0], r_quo[DATA_WIDTH-1]};
  assign w_sub    = (r_rem[RW-1] == w_b_ext[DATA_WIDTH]);
  assign w_rem_nx = w_sub ? (w_rem_sh - w_b_rw) : (w_rem_sh + w_b_rw);

  // Digits are +1/-1: quotient = 2*bits + 1 - 2^N, whose low N bits are {bits[N-2:0], 1}
  always_comb begin
    w_rem_fix = r_rem;
    w_quo_fix = {r_quo[DATA_WIDTH-2:0], 1'b1};
    if (r_rem != '0 && r_rem[RW-1] != w_a_ext[DATA_WIDTH]) begin
      if (r_rem[RW-1] == w_b_ext[DATA_WIDTH]) begin
        w_rem_fix = r_rem - w_b_rw;
        w_quo_fix = w_quo_fix + 1'b1;
      end else begin
        w_rem_fix = r_rem + w_b_rw;
        w_quo_fix = w_quo_fix - 1'b1;
      end
    end
    if (w_rem_fix == w_b_rw) begin
      w_rem_fix = '0;
      w_quo_fix = w_quo_fix + 1'b1;
    end else if ((w_rem_fix + w_b_rw) == '0) begin
      w_rem_fix = '0;
      w_quo_fix = w_quo_fix - 1'b1;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_pop      = 1'b0;
    w_preset   = 1'b0;
    w_step     = 1'b0;
    w_res_load = 1'b0;
    w_res_data = '0;
    unique case (r_state)
      IDLE: begin
        if (r_vis && w_out_free) begin
          if (w_div_zero) begin
            w_res_load = 1'b1;
            w_pop      = 1'b1;
            w_res_data = w_head.rem_sel ? w_head.op_a : '1;
          end else if (w_ovf) begin
            w_res_load = 1'b1;
            w_pop      = 1'b1;
            w_res_data = w_head.rem_sel ? '0 : w_head.op_a;
          end else begin
            w_preset  = 1'b1;
            w_state_d = CALC;
          end
        end
      end
      CALC: begin
        w_step = 1'b1;
        if (r_cnt_calc == CntW'(DATA_WIDTH - 1)) w_state_d = FIX;
      end
      FIX: begin
        if (w_out_free) begin
          w_res_load = 1'b1;
          w_pop      = 1'b1;
          w_res_data = w_head.rem_sel ? w_rem_fix[DATA_WIDTH-1:0] : w_quo_fix;
          w_state_d  = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
    if (flush) begin
      w_state_d  = IDLE;
      w_pop      = 1'b0;
      w_preset   = 1'b0;
      w_step     = 1'b0;
      w_res_load = 1'b0;
    end
  end

  // r_vis: head entry has sat in the buffer for at least one cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_cnt      <= 2'd0;
      r_vis      <= 1'b0;
      r_cnt_calc <= '0;
      r_res_vld  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (flush) begin
        r_wptr     <= 1'b0;
        r_rptr     <= 1'b0;
        r_cnt      <= 2'd0;
        r_vis      <= 1'b0;
        r_cnt_calc <= '0;
        r_res_vld  <= 1'b0;
      end else begin
        if (w_push) r_wptr <= ~r_wptr;
        if (w_pop)  r_rptr <= ~r_rptr;
        r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        r_vis <= ((r_cnt - {1'b0, w_pop}) != 2'd0);
        if (w_preset)    r_cnt_calc <= '0;
        else if (w_step) r_cnt_calc <= r_cnt_calc + 1'b1;
        if (w_res_load)                r_res_vld <= 1'b1;
        else if (div.m_div_res_ready)  r_res_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_buf[r_wptr] <= w_in;
    if (w_preset) begin
      r_rem <= {RW{w_a_ext[DATA_WIDTH]}};
      r_quo <= w_head.op_a;
    end else if (w_step) begin
      r_rem <= w_rem_nx;
      r_quo <= {r_quo[DATA_WIDTH-2:0], w_sub};
    end
    if (w_res_load) begin
      r_res_data <= w_res_data;
      r_res_id   <= w_head.id;
    end
  end
endmodule

// File: doc/panda_risc_v_divider_param.md
PANDA_RISC_V_DIVIDER_PARAM -- requirements
Module: panda_risc_v_divider_param

Interface
- Parameters (name, default, meaning)
  - REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: operand and result width N (allowed 8..64).
  - REQ-002 The block SHALL have parameter ID_WIDTH, default 4: width of the request tag carried through to the result.
  - REQ-003 The block SHALL have parameter simulation_delay, real, default 1: register update delay, simulation only.
- Ports (name, direction, width, meaning)
  - REQ-004 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
  - REQ-005 The block SHALL have port resetn, input, 1: reset, asynchronous, active-low.
  - REQ-006 The block SHALL have port s_div_req_op_a, input, N: dividend.
  - REQ-007 The block SHALL have port s_div_req_op_b, input, N: divisor.
  - REQ-008 The block SHALL have port s_div_req_signed, input, 1: 1 = signed operands, 0 = unsigned.
  - REQ-009 The block SHALL have port s_div_req_rem_sel, input, 1: 0 = return quotient, 1 = return remainder.
  - REQ-010 The block SHALL have port s_div_req_id, input, ID_WIDTH: request tag.
  - REQ-011 The block SHALL have ports s_div_req_valid (input, 1) and s_div_req_ready (output, 1): request handshake.
  - REQ-012 The block SHALL have port m_div_res_data, output, N: result.
  - REQ-013 The block SHALL have port m_div_res_id, output, ID_WIDTH: tag of the request that produced the result.
  - REQ-014 The block SHALL have ports m_div_res_valid (output, 1) and m_div_res_ready (input, 1): result handshake.
  - REQ-015 The block SHALL have port flush, input, 1: synchronous cancel of all outstanding work.

Function
- REQ-016 Request transfer SHALL occur on a clock edge with valid & ready high.
- REQ-017 Accepted requests SHALL enter a 2-entry FWFT input buffer.
- REQ-018 s_div_req_ready SHALL equal the input buffer's not-full flag.
- REQ-019 Results SHALL be returned strictly in acceptance order.
- REQ-020 Operands SHALL be extended internally to N+1 bits: sign-extended when s_div_req_signed=1, zero-extended when 0.
- REQ-021 Division SHALL use the non-restoring algorithm at one quotient bit per cycle.
- REQ-022 The FSM SHALL have states IDLE, CALC, FIX and no others.
- REQ-023 IDLE with the buffer non-empty and the output register free SHALL:
  - bypass directly to the output register on divide-by-zero or signed overflow;
  - otherwise preset the remainder/quotient registers and go to CALC.
- REQ-024 CALC SHALL run exactly N cycles, counted by a cycle counter, then go to FIX.
- REQ-025 FIX SHALL:
  - apply remainder correction (remainder sign differs from dividend sign, nonzero) and quotient correction;
  - apply exact-division correction (remainder equals +/- divisor: remainder becomes 0, quotient adjusted by 1 toward the true value);
  - write the output register, pop the buffer, and return to IDLE.
- REQ-026 FIX SHALL hold (stall) while the output register is occupied and m_div_res_ready is low.
- REQ-027 Signed results SHALL satisfy: quotient truncated toward zero; remainder sign equals dividend sign; a = q*b + r.
- REQ-028 Divide-by-zero SHALL return quotient all ones and remainder equal to the dividend, in both modes.
- REQ-029 Signed overflow (dividend = -2^(N-1), divisor = -1) SHALL return quotient = dividend and remainder = 0.
- REQ-030 Latency from the acceptance edge k to m_div_res_valid high SHALL be:
  - normal: after edge k+N+3 (1 cycle buffer, 1 cycle preset, N cycles CALC, 1 cycle FIX);
  - bypass: after edge k+2.
- REQ-031 The output register SHALL be a single stage: it loads when empty or when m_div_res_ready=1; m_div_res_data and m_div_res_id SHALL be held stable while valid & ~ready.
- REQ-032 Throughput SHALL be back-to-back: the next IDLE evaluation occurs in the cycle after FIX.
- REQ-033 flush=1 on an edge SHALL:
  - empty the buffer;
  - return the FSM to IDLE;
  - clear m_div_res_valid;
  - drop any request presented in the same cycle (flush wins over simultaneous valid);
  - never produce a result afterwards for cancelled work.

Reset
- REQ-034 On resetn=0 the block SHALL asynchronously:
  - enter IDLE;
  - empty the buffer;
  - clear the cycle counter.
- REQ-035 During reset, m_div_res_valid=0 and s_div_req_ready=1.
- REQ-036 m_div_res_data and m_div_res_id SHALL have no reset value.
- REQ-037 Reset asserted mid-CALC SHALL discard the operation and produce no result after release.

Verification (N=32)
- REQ-038 A bench SHALL cover: signed -7 / 2, rem_sel=0 then 1 -> 0xFFFFFFFD, then 0xFFFFFFFF; each valid 35 cycles after acceptance.
- REQ-039 A bench SHALL cover: unsigned 0xFFFFFFFF / 0x10 -> quotient 0x0FFFFFFF, remainder 0xF; signed -6 / 3 -> quotient 0xFFFFFFFE, remainder 0.
- REQ-040 A bench SHALL cover: 5 / 0 -> quotient 0xFFFFFFFF, remainder 5; signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; both valid 2 cycles after acceptance.
- REQ-041 A bench SHALL cover: m_div_res_ready held low while 4 requests (ids 1..4) are presented back to back.
  - Required: s_div_req_ready falls once the buffer and output are full.
  - Required: results emerge in order 1..4, unchanged under stall.
- REQ-042 A bench SHALL cover: flush pulsed at CALC cycle 10 with a second request buffered.
  - Required: no result and buffer empty after the flush.
  - Required: the following request 100 / 7 returns 14.
- REQ-043 A bench SHALL cover: resetn pulsed low mid-CALC.
  - Required: m_div_res_valid=0 and s_div_req_ready=1 immediately.
  - Required: no spurious result after release.
